// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/jump flushes, memory freeze and HALT/resume.
// Optional performance counters are built only when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
    parameter int LOAD_BUBBLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ifidRs,
    input  logic [4:0]  ifidRt,
    input  logic        ifidUsesRt,
    input  logic        idexMemRead,
    input  logic [4:0]  idexRt,
    input  logic        branchTaken,
    input  logic        jump,
    input  logic        haltId,
    input  logic        resume,
    input  logic        memBusy,
    output logic        pcEnable,
    output logic        ifidEnable,
    output logic        ifidClear,
    output logic        idexEnable,
    output logic        idexClear,
    output logic        exmemEnable,
    output logic        memwbEnable,
    output logic        halted,
    output logic [31:0] stallCycles,
    output logic [15:0] flushCount
);

    typedef enum logic [1:0] {RUN, LDUSE, HALTED} state_t;

    localparam logic [1:0] CNT_INIT = 2'(LOAD_BUBBLES - 1);

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       halted_q;
    logic       load_use;
    logic       pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, memwb_en;

    assign load_use = idexMemRead && (idexRt != 5'd0) &&
                      ((idexRt == ifidRs) || (ifidUsesRt && (idexRt == ifidRt)));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        ifid_clr = 1'b0;
        idex_en  = 1'b1;
        idex_clr = 1'b0;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
        if (memBusy) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (load_use) begin
                        pc_en    = 1'b0;
                        ifid_en  = 1'b0;
                        idex_clr = 1'b1;
                        cnt_d    = CNT_INIT;
                        state_d  = (LOAD_BUBBLES == 1) ? RUN : LDUSE;
                    end else if (haltId) begin
                        pc_en    = 1'b0;
                        ifid_clr = 1'b1;
                        state_d  = HALTED;
                    end else if (branchTaken || jump) begin
                        // PC stays enabled so it loads the branch/jump target.
                        ifid_clr = 1'b1;
                    end
                end
                LDUSE: begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_clr = 1'b1;
                    cnt_d    = cnt_q - 2'd1;
                    if (cnt_q == 2'd1) state_d = RUN;
                end
                HALTED: begin
                    pc_en    = 1'b0;
                    ifid_clr = 1'b1;
                    if (resume) state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= RUN;
            cnt_q    <= 2'd0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            halted_q <= (state_d == HALTED);
        end
    end

    // Reset gates every enable/clear low immediately, independent of the clock.
    assign pcEnable    = reset & pc_en;
    assign ifidEnable  = reset & ifid_en;
    assign ifidClear   = reset & ifid_clr;
    assign idexEnable  = reset & idex_en;
    assign idexClear   = reset & idex_clr;
    assign exmemEnable = reset & exmem_en;
    assign memwbEnable = reset & memwb_en;
    assign halted      = halted_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_q, stall_d;
    logic [15:0] flush_q, flush_d;

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!memBusy) begin
            if (!pc_en && (state_q != HALTED)) stall_d = stall_q + 32'd1;
            if (ifid_clr && (state_q == RUN))  flush_d = flush_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= 32'd0;
            flush_q <= 16'd0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stallCycles = stall_q;
    assign flushCount  = flush_q;
`else
    assign stallCycles = 32'd0;
    assign flushCount  = 16'd0;
`endif

endmodule
